// File: rtl/signal_chain_monitor.sv
// Per-channel register chains with change detection; changes are timestamped,
// arbitrated lowest-channel-first and queued in a small event FIFO.
module signal_chain_monitor #(
  parameter int CHANNELS   = 2,
  parameter int WIDTH      = 1,
  parameter int STAGES     = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int TS_WIDTH   = 16
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [CHANNELS*WIDTH-1:0]                      in_data,
  output logic [CHANNELS*WIDTH-1:0]                      out_data,
  output logic                                           evt_valid,
  input  logic                                           evt_ready,
  output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] evt_chan,
  output logic [WIDTH-1:0]                               evt_data,
  output logic [TS_WIDTH-1:0]                            evt_time,
  output logic                                           overflow,
  input  logic                                           clear_ovf
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = CW + WIDTH + TS_WIDTH;

  logic [WIDTH-1:0]    chain_r     [CHANNELS][STAGES];
  logic [WIDTH-1:0]    prev_r      [CHANNELS];
  logic [WIDTH-1:0]    slot_data_r [CHANNELS];
  logic [TS_WIDTH-1:0] slot_time_r [CHANNELS];
  logic [CHANNELS-1:0] pend_r;
  logic [TS_WIDTH-1:0] ts_r;
  logic [EW-1:0]       mem_r [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_r, rd_ptr_r;
  logic [AW:0]         count_r;
  logic                ovf_r;

  logic [CHANNELS-1:0] change_s, push_mask_s;
  logic [CW-1:0]       grant_s;
  logic                any_pend_s, push_s, pop_s, full_s, ovf_set_s;

  // channel register chains
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++)
        for (int k = 0; k < STAGES; k++)
          chain_r[c][k] <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++)
        for (int k = 0; k < STAGES; k++)
          chain_r[c][k] <= (k == 0) ? in_data[c*WIDTH +: WIDTH] : chain_r[c][(k > 0) ? k-1 : 0];
    end
  end

  // previous-output copy and free-running timestamp
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_r <= '0;
      for (int c = 0; c < CHANNELS; c++) prev_r[c] <= '0;
    end else begin
      ts_r <= ts_r + TS_WIDTH'(1);
      for (int c = 0; c < CHANNELS; c++) prev_r[c] <= chain_r[c][STAGES-1];
    end
  end

  // change detection, arbitration and FIFO handshake decode
  always_comb begin
    grant_s    = '0;
    any_pend_s = 1'b0;
    for (int c = CHANNELS-1; c >= 0; c--) begin
      grant_s    = pend_r[c] ? CW'(c) : grant_s;
      any_pend_s = any_pend_s | pend_r[c];
    end
    full_s = (count_r == (AW+1)'(FIFO_DEPTH));
    pop_s  = (count_r != '0) && evt_ready;
    push_s = any_pend_s && (!full_s || pop_s);
    for (int c = 0; c < CHANNELS; c++) begin
      out_data[c*WIDTH +: WIDTH] = chain_r[c][STAGES-1];
      change_s[c]    = (chain_r[c][STAGES-1] != prev_r[c]);
      push_mask_s[c] = push_s && (grant_s == CW'(c));
    end
    // a newer change only loses an event if the old one is not leaving this cycle
    ovf_set_s = |(change_s & pend_r & ~push_mask_s);
  end

  // pending slots: a new change always wins over a same-cycle push
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_r <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        slot_data_r[c] <= '0;
        slot_time_r[c] <= '0;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (change_s[c]) begin
          pend_r[c]      <= 1'b1;
          slot_data_r[c] <= chain_r[c][STAGES-1];
          slot_time_r[c] <= ts_r;
        end else if (push_mask_s[c]) begin
          pend_r[c] <= 1'b0;
        end else begin
          pend_r[c] <= pend_r[c];
        end
      end
    end
  end

  // event FIFO storage and pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= '0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= {grant_s, slot_data_r[grant_s], slot_time_r[grant_s]};
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // sticky overflow, set beats clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            ovf_r <= 1'b0;
    else if (ovf_set_s) ovf_r <= 1'b1;
    else if (clear_ovf) ovf_r <= 1'b0;
    else                ovf_r <= ovf_r;
  end

  assign evt_valid                      = (count_r != '0);
  assign {evt_chan, evt_data, evt_time} = mem_r[rd_ptr_r];
  assign overflow                       = ovf_r;
endmodule

// File: tb/tb_signal_chain_monitor.sv
// Randomized scoreboard bench: a delay-line/event-list reference model predicts
// the event stream, out_data and overflow; a negedge monitor compares.
module tb_signal_chain_monitor;
  localparam int CH = 3, W = 2, ST = 2, FD = 4, TW = 4, CW = 2;

  logic              clk = 1'b0;
  logic              rst, evt_ready, clear_ovf, evt_valid, overflow;
  logic [CH*W-1:0]   in_data, out_data;
  logic [CW-1:0]     evt_chan;
  logic [W-1:0]      evt_data;
  logic [TW-1:0]     evt_time;

  signal_chain_monitor #(.CHANNELS(CH), .WIDTH(W), .STAGES(ST), .FIFO_DEPTH(FD), .TS_WIDTH(TW)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .out_data(out_data),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_chan(evt_chan),
    .evt_data(evt_data), .evt_time(evt_time), .overflow(overflow), .clear_ovf(clear_ovf));

  always #5 clk = ~clk;

  typedef struct packed { logic [CW-1:0] chan; logic [W-1:0] data; logic [TW-1:0] tim; } evt_t;
  evt_t exp_q[$];
  int checks = 0, passed = 0;

  logic [CH*W-1:0] dly_q[$];
  logic [CH*W-1:0] m_out, m_prev;
  int              m_ts, m_count;
  bit              m_pend[CH];
  logic [W-1:0]    m_sd[CH];
  int              m_st[CH];
  bit              m_ovf;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    dly_q.delete();
    repeat (ST) dly_q.push_back('0);
    m_out = '0; m_prev = '0; m_ts = 0; m_count = 0; m_ovf = 1'b0;
    for (int c = 0; c < CH; c++) begin m_pend[c] = 1'b0; m_sd[c] = '0; m_st[c] = 0; end
    exp_q.delete();
  endtask

  // one clock edge of the reference behaviour, using the inputs present before the edge
  task automatic model_step();
    int  g;
    bit  pop, set;
    evt_t e;
    if (rst) begin model_reset(); return; end
    pop = (m_count > 0) && evt_ready;
    g = -1;
    for (int c = CH-1; c >= 0; c--) if (m_pend[c]) g = c;
    if (g >= 0 && (m_count < FD || pop)) begin
      e.chan = CW'(g); e.data = m_sd[g]; e.tim = TW'(m_st[g]);
      exp_q.push_back(e);
      m_pend[g] = 1'b0;
      m_count++;
    end
    if (pop) m_count--;
    set = 1'b0;
    for (int c = 0; c < CH; c++) begin
      if (m_out[c*W +: W] != m_prev[c*W +: W]) begin
        if (m_pend[c]) set = 1'b1;
        m_pend[c] = 1'b1;
        m_sd[c]   = m_out[c*W +: W];
        m_st[c]   = m_ts;
      end
    end
    m_ovf  = set ? 1'b1 : (clear_ovf ? 1'b0 : m_ovf);
    m_prev = m_out;
    dly_q.push_back(in_data);
    void'(dly_q.pop_front());
    m_out = dly_q[0];
    m_ts  = (m_ts + 1) % (1 << TW);
  endtask

  task automatic cyc(logic [CH*W-1:0] din, logic rdy, logic clr);
    @(posedge clk);
    model_step();
    #2;
    in_data = din; evt_ready = rdy; clear_ovf = clr;
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_valid"}, evt_valid, 1'b0);
    chk({tag, "_out"}, out_data, '0);
    chk({tag, "_ovf"}, overflow, 1'b0);
    chk({tag, "_evt"}, {evt_chan, evt_data, evt_time}, '0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    evt_t e;
    if (!rst) begin
      chk("evt_valid", evt_valid, exp_q.size() != 0);
      chk("out_data", out_data, m_out);
      chk("overflow", overflow, m_ovf);
      if (evt_valid && exp_q.size() > 0) begin
        e = exp_q[0];
        chk("evt_chan", evt_chan, e.chan);
        chk("evt_data", evt_data, e.data);
        chk("evt_time", evt_time, e.tim);
        if (evt_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [CH*W-1:0] v;
    rst = 1'b1; in_data = '0; evt_ready = 1'b0; clear_ovf = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("por");
    repeat (3) cyc('0, 1'b1, 1'b0);
    rst = 1'b0;
    // all channels change together: ch0, ch1, ch2 on consecutive cycles, same time
    repeat (4) cyc('0, 1'b1, 1'b0);
    cyc('1, 1'b1, 1'b0);
    repeat (10) cyc('1, 1'b1, 1'b0);
    // five isolated changes on ch0 with the consumer stalled, then a single pop
    v = '1;
    for (int i = 0; i < 5; i++) begin
      v[0] = ~v[0];
      cyc(v, 1'b0, 1'b0);
      repeat (3) cyc(v, 1'b0, 1'b0);
    end
    cyc(v, 1'b1, 1'b0);
    repeat (3) cyc(v, 1'b0, 1'b0);
    // back-to-back toggles on ch1 while full -> overflow, newest value kept
    v[2] = ~v[2]; cyc(v, 1'b0, 1'b0);
    v[2] = ~v[2]; cyc(v, 1'b0, 1'b0);
    repeat (5) cyc(v, 1'b0, 1'b0);
    cyc(v, 1'b1, 1'b1);
    repeat (12) cyc(v, 1'b1, 1'b0);
    // mid-operation reset with queued events, nonzero input held through reset
    for (int i = 0; i < 6; i++) cyc(CH*W'(i * 7), 1'b0, 1'b0);
    @(posedge clk); model_step(); #2;
    rst = 1'b1; in_data = 6'b01_10_11;
    #1;
    check_reset_outputs("mid_rst");
    repeat (3) cyc(6'b01_10_11, 1'b1, 1'b0);
    rst = 1'b0;
    repeat (10) cyc(6'b01_10_11, 1'b1, 1'b0);
    // randomized traffic
    v = 6'b01_10_11;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) v = CH*W'($urandom);
      cyc(v, ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
    end
    repeat (20) cyc(v, 1'b1, 1'b0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
